// File: rtl/fifo_rd_pkg.sv
// Shared encodings and sizes for the FIFO read-side stream stage.
// Optional handshake counter is enabled by FIFO_RD_STREAM_CNT_EN.
package fifo_rd_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } rd_state_e;

    localparam int SKID_DEPTH = 2;
    localparam int CNT_WIDTH  = 16;

    // Slots committed after this cycle: buffered + in flight - leaving now.
    // A pop implies occ >= 1, so the subtraction never wraps.
    function automatic logic [1:0] slots_used(input logic [1:0] occ,
                                              input logic       infl,
                                              input logic       pop);
        return occ + {1'b0, infl} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// 2-entry in-order skid buffer; head is always entry 0, entries shift on pop.
// Same-cycle push/pop supported; clear wins over push and pop.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_dat_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_dat_o,
    output logic [1:0]            occ_o
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic [1:0]            wr_pos;

    always_comb begin
        mem_d  = mem_q;
        occ_d  = occ_q;
        wr_pos = occ_q - {1'b0, pop_i};
        if (clr_i) begin
            occ_d = 2'd0;
        end else begin
            if (pop_i) begin
                mem_d[0] = mem_q[1];
            end
            // Write slot is computed after the shift so push+pop lands correctly.
            if (push_i) begin
                mem_d[wr_pos[0]] = push_dat_i;
            end
            occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= 2'd0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            mem_q <= mem_d;
        end
    end

    assign head_dat_o = mem_q[0];
    assign occ_o      = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains an async FIFO (1-cycle read latency) into a valid/ready stream; optional counter via FIFO_RD_STREAM_CNT_EN.
// Latency: FIFO non-empty at cycle N gives m_valid at N+2; 1 word/cycle sustained.
// Backpressure: reads are issued only when the 2-entry skid buffer has room for them; flush drains the FIFO.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [DATA_WIDTH-1:0] f_data,
    input  logic                  f_empty,
    output logic                  r_en,
    input  logic                  flush,
    output logic                  flush_busy,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  xfer_cnt
);

    rd_state_e  state_q;
    logic       inflight_q;
    logic       busy_q;
    logic [1:0] occ;
    logic       run;
    logic       pop;
    logic       push;
    logic       rd_acc;
    logic       flush_go;

    always_comb begin
        run      = (state_q == ST_RUN);
        m_valid  = run & (occ != 2'd0);
        pop      = m_valid & m_ready;
        flush_go = run & flush;
        if (run) begin
            r_en = !f_empty & (slots_used(occ, inflight_q, pop) < 2'd2);
        end else begin
            r_en = !f_empty;
        end
        rd_acc = r_en & !f_empty;
        // Words landing during a flush (or on its entry cycle) are dropped.
        push   = inflight_q & run & !flush_go;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q    <= ST_RUN;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            inflight_q <= rd_acc;
            case (state_q)
                ST_RUN: begin
                    if (flush) begin
                        state_q <= ST_FLUSH;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (f_empty && !inflight_q) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign flush_busy = busy_q;

    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (rclk),
        .rst_n      (rrst_n),
        .clr_i      (flush_go),
        .push_i     (push),
        .push_dat_i (f_data),
        .pop_i      (pop),
        .head_dat_o (m_data),
        .occ_o      (occ)
    );

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural async-FIFO read port plus an expected-word queue.
module tb_fifo_rd_stream;

    localparam int DW = 8;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic [DW-1:0] f_data = '0;
    logic          f_empty = 1'b1;
    logic          r_en;
    logic          flush = 1'b0;
    logic          flush_busy;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic [15:0]   xfer_cnt;

    fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .f_data     (f_data),
        .f_empty    (f_empty),
        .r_en       (r_en),
        .flush      (flush),
        .flush_busy (flush_busy),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .xfer_cnt   (xfer_cnt)
    );

    always #5 rclk = ~rclk;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] wq[$];
    logic [DW-1:0] expq[$];
    int            rd_cnt = 0;
    int            hs_total = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    logic          last_hs = 1'b0;

    // Async FIFO read port: registered empty flag, data one cycle after an accepted read.
    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            fq.delete();
            f_empty <= 1'b1;
            f_data  <= '0;
        end else begin
            if (r_en && !f_empty) begin
                f_data <= fq.pop_front();
                rd_cnt++;
            end
            while (wq.size() > 0) fq.push_back(wq.pop_front());
            f_empty <= (fq.size() == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt();
`ifdef FIFO_RD_STREAM_CNT_EN
        return 16'(hs_total);
`else
        return 16'd0;
`endif
    endfunction

    task automatic wr(input logic [DW-1:0] d);
        wq.push_back(d);
        expq.push_back(d);
    endtask

    // One clock: record the handshake seen before the edge, then score it afterwards.
    task automatic tick();
        logic          hs;
        logic          stall;
        logic          fl;
        logic [DW-1:0] d;
        #1;
        hs    = m_valid & m_ready;
        fl    = flush;
        stall = m_valid & !m_ready & !fl;
        d     = m_data;
        @(posedge rclk);
        @(negedge rclk);
        last_hs = hs;
        if (hs) begin
            hs_total++;
            if (expq.size() == 0) check("unexpected_hs", {24'd0, d}, 32'hFFFF_FFFF);
            else                  check("hs_data", {24'd0, d}, {24'd0, expq.pop_front()});
        end
        if (fl) expq.delete();
        if (stall) begin
            check("hold_valid", {31'd0, m_valid}, 32'd1);
            check("hold_data", {24'd0, m_data}, {24'd0, d});
        end
        flush = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int first_word;
        int rd0;
        int nhs;
        logic done;

        // Reset with random m_ready
        for (int i = 0; i < 6; i++) begin
            m_ready = 1'($urandom);
            @(negedge rclk);
            check("rst_r_en", {31'd0, r_en}, 32'd0);
            check("rst_m_valid", {31'd0, m_valid}, 32'd0);
            check("rst_busy", {31'd0, flush_busy}, 32'd0);
            check("rst_m_data", {24'd0, m_data}, 32'd0);
        end
        check("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
        rrst_n = 1'b1;
        m_ready = 1'b1;
        ticks(2);

        // Three words, latency check
        wr(8'h11); wr(8'h22); wr(8'h33);
        tick();
        check("lat_f_empty_fell", {31'd0, f_empty}, 32'd0);
        check("lat_r_en_N", {31'd0, r_en}, 32'd1);
        check("lat_valid_N", {31'd0, m_valid}, 32'd0);
        tick();
        check("lat_valid_N1", {31'd0, m_valid}, 32'd0);
        tick();
        check("lat_valid_N2", {31'd0, m_valid}, 32'd1);
        check("lat_data_N2", {24'd0, m_data}, 32'h11);
        nhs = 0;
        for (int i = 0; i < 3; i++) begin tick(); nhs += int'(last_hs); end
        check("b2b_count", nhs, 3);
        ticks(3);
        check("three_drained", expq.size(), 0);
        check("cnt_after_three", {16'd0, xfer_cnt}, {16'd0, exp_cnt()});

        // Full FIFO under stall
        m_ready = 1'b0;
        first_word = int'($urandom_range(0, 255));
        wr(8'(first_word));
        for (int i = 1; i < 8; i++) wr(8'($urandom));
        rd0 = rd_cnt;
        ticks(11);
        check("stall_reads", rd_cnt - rd0, 2);
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_head", {24'd0, m_data}, first_word);
        check("stall_r_en", {31'd0, r_en}, 32'd0);
        m_ready = 1'b1;
        nhs = 0;
        for (int i = 0; i < 8; i++) begin tick(); nhs += int'(last_hs); end
        check("full_no_gaps", nhs, 8);
        ticks(3);
        check("full_drained", expq.size(), 0);

        // Toggling backpressure
        for (int i = 0; i < 8; i++) wr(8'($urandom));
        for (int i = 0; i < 30; i++) begin m_ready = ~m_ready; tick(); end
        m_ready = 1'b1;
        ticks(4);
        check("toggle_drained", expq.size(), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if (($urandom_range(0, 1) == 1) && (fq.size() + wq.size() < 8)) wr(8'($urandom));
            tick();
        end
        m_ready = 1'b1;
        ticks(20);
        check("random_drained", expq.size(), 0);
        check("cnt_after_random", {16'd0, xfer_cnt}, {16'd0, exp_cnt()});

        // Flush after first handshake
        for (int i = 0; i < 5; i++) wr(8'($urandom));
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin tick(); done = last_hs; end
        check("flush_first_hs_seen", {31'd0, done}, 32'd1);
        flush = 1'b1;
        tick();
        check("flush_valid_drop", {31'd0, m_valid}, 32'd0);
        check("flush_busy_set", {31'd0, flush_busy}, 32'd1);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (i == 1) flush = 1'b1;
            tick();
            if (m_valid) check("flush_valid_low", {31'd0, m_valid}, 32'd0);
            done = !flush_busy;
        end
        check("flush_ended", {31'd0, done}, 32'd1);
        check("flush_fifo_empty", fq.size(), 0);
        check("flush_f_empty", {31'd0, f_empty}, 32'd1);
        wr(8'h55);
        ticks(6);
        check("post_flush_drained", expq.size(), 0);
        check("cnt_after_flush", {16'd0, xfer_cnt}, {16'd0, exp_cnt()});

        // Reset in the middle of traffic
        for (int i = 0; i < 6; i++) wr(8'($urandom));
        ticks(3);
        rrst_n = 1'b0;
        #1;
        check("mid_rst_r_en", {31'd0, r_en}, 32'd0);
        check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_data", {24'd0, m_data}, 32'd0);
        check("mid_rst_cnt", {16'd0, xfer_cnt}, 32'd0);
        expq.delete();
        wq.delete();
        hs_total = 0;
        @(negedge rclk);
        rrst_n = 1'b1;
        wr(8'hA5); wr(8'h5A);
        ticks(6);
        check("after_rst_drained", expq.size(), 0);
        check("cnt_after_rst", {16'd0, xfer_cnt}, {16'd0, exp_cnt()});

`ifdef FIFO_RD_STREAM_CNT_EN
        // Counter wrap: 65537 handshakes since reset
        rrst_n = 1'b0;
        expq.delete();
        wq.delete();
        hs_total = 0;
        @(negedge rclk);
        rrst_n = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 70000 && hs_total < 65537; i++) begin
            if (fq.size() + wq.size() < 6 && (hs_total + expq.size()) < 65537) wr(8'($urandom));
            tick();
        end
        check("wrap_reached", hs_total, 65537);
        check("wrap_cnt", {16'd0, xfer_cnt}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage placed directly downstream of the asynchronous FIFO, in the read clock domain. Issues `r_en` to the FIFO, absorbs the FIFO's one-cycle registered read latency, and presents the words as a valid/ready stream through a 2-entry skid buffer. Supports a flush that discards all FIFO contents, plus an optional handshake counter.

## Interface
- `DATA_WIDTH`, 8, width of FIFO words and stream data
- `rclk`  in  1  read-domain clock, rising edge
- `rrst_n`  in  1  asynchronous, active-low reset
- `f_data`  in  DATA_WIDTH  FIFO `data_out`; updates one cycle after an accepted read
- `f_empty`  in  1  FIFO `empty` flag, registered in the `rclk` domain
- `r_en`  out  1  read request to the FIFO
- `flush`  in  1  single-cycle pulse; discard everything buffered and everything in the FIFO
- `flush_busy`  out  1  high while a flush is in progress
- `m_valid`  out  1  stream data valid
- `m_data`  out  DATA_WIDTH  stream data; held stable while `m_valid & !m_ready`
- `m_ready`  in  1  downstream accept
- `xfer_cnt`  out  16  count of stream handshakes (see Configuration)

## Operation
- Accepted read: `rd_acc = r_en & !f_empty`. The FIFO gates reads internally, so `r_en` high while empty is harmless. Only `rd_acc` counts as a read.
- `inflight` register is set on `rd_acc` and cleared the next cycle. When `inflight` is set, `f_data` is captured into the buffer tail.
- Skid buffer: 2 entries, FIFO order, occupancy `occ` in 0..2.
  - `m_valid = (occ != 0)` in RUN.
  - `m_data` is the buffer head.
  - Pop: `pop = m_valid & m_ready`.
- RUN issue rule: `r_en = !f_empty & (occ + inflight - pop < 2)`. Arithmetic is 2-bit unsigned and cannot underflow, because `pop` implies `occ >= 1`.
  - Sustains 1 word/cycle with `m_ready` held high.
  - The buffer can never overflow.
- States:
  - RUN (reset state): normal operation.
  - FLUSH: entered on `flush` from RUN.
    - Entry clears `occ`; `m_valid = 0`.
    - `r_en = !f_empty`; arriving `f_data` is discarded.
    - `flush_busy = 1`.
    - Exit to RUN when `f_empty & !inflight`.
- `flush` asserted while already in FLUSH is ignored.
- `flush` and `pop` in the same cycle: the pop completes (the data was accepted), then FLUSH is entered.
- Reset mid-operation: all state is cleared immediately and asynchronously. The FIFO resets independently; no handshake is needed.

## Timing
- Reset values: `r_en=0`, `m_valid=0`, `m_data=0`, `flush_busy=0`, `xfer_cnt=0`, state RUN, `occ=0`, `inflight=0`.
- Latency from FIFO non-empty to stream:
  - `f_empty` falls at cycle N, so `r_en=1` at N.
  - `f_data` is valid at N+1 and captured at the end of N+1.
  - `m_valid=1` at N+2.
- Combinational paths: `m_ready -> r_en` and `f_empty -> r_en`. All other outputs are registered or decoded from registers.
- `m_valid` must not drop without a handshake, except on flush or reset.

## Configuration
- `FIFO_RD_STREAM_CNT_EN` defined:
  - `xfer_cnt` increments on every `pop`.
  - 16-bit counter, wraps from 0xFFFF to 0.
  - Cleared only by reset; a flush does not clear it.
- Not defined: `xfer_cnt` is tied to 0 and no counter flops are built. The port list is identical in both builds.

## Structure
- Shared package/header `fifo_rd_pkg` holds:
  - state encodings `ST_RUN=1'b0`, `ST_FLUSH=1'b1`
  - `SKID_DEPTH=2`
  - `CNT_WIDTH=16`
- One sub-module, `rd_skid_buf`:
  - contains the 2-entry storage, occupancy, push/pop/clear
  - parameterised by `DATA_WIDTH`
- The top level holds the issue logic, `inflight`, the state machine and the counter.

## Test plan
- Reset with `f_empty=1` and random `m_ready`: `r_en`, `m_valid` and `flush_busy` stay 0 and `m_data=0`.
- Write 0x11,0x22,0x33 into the async FIFO, `m_ready=1`: stream emits 0x11,0x22,0x33 on consecutive cycles, first `m_valid` two cycles after `f_empty` falls.
- Full FIFO (8 words), `m_ready=0` for 10 cycles: exactly 2 reads accepted, `m_data` held at the first word, `r_en` low afterwards. Then `m_ready=1`: all 8 words arrive in order with no gaps.
- Back-pressure toggling `m_ready` every cycle over 8 words: no loss, no duplication, order preserved.
- 5 words in the FIFO, `flush` pulse after the first handshake: `m_valid` drops the next cycle, `flush_busy` stays high until the FIFO is empty and `inflight=0`. Then write 0x55: it is the next word streamed.
- With `FIFO_RD_STREAM_CNT_EN`: after 65537 handshakes `xfer_cnt=1`. Without the macro: `xfer_cnt` is always 0.
